// File: rtl/counter_x.sv
// -----------------------------------------------------------------------------
// counter_x
//   Three independent 32-bit down-counters with a shared 12-bit control register.
//   Each channel has a count register, a reload register and one output bit.
//   Each channel runs in one of three modes:
//     - one-shot: out sticks at 1 after expiry.
//     - periodic pulse: out is a one-cycle pulse on every expiry.
//     - square wave: out toggles on every expiry.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   counter_we   write strobe
//   counter_ch   target select: 0..2 channel count/reload, 3 control register
//   counter_val  write data
//   counter_out  combinational readback of the selected count (or control)
//   counter0_out channel 0 output bit (registered)
//   counter1_out channel 1 output bit (registered)
//   counter2_out channel 2 output bit (registered)
// -----------------------------------------------------------------------------
module counter_x (
    input  logic        clk,
    input  logic        rst,
    input  logic        counter_we,
    input  logic [1:0]  counter_ch,
    input  logic [31:0] counter_val,
    output logic [31:0] counter_out,
    output logic        counter0_out,
    output logic        counter1_out,
    output logic        counter2_out
);

    typedef enum logic [1:0] {
        MODE_ONESHOT     = 2'b00,
        MODE_PERIODIC    = 2'b01,
        MODE_SQUARE      = 2'b10,
        MODE_ONESHOT_ALT = 2'b11
    } mode_e;

    logic [31:0] count_q  [3];
    logic [31:0] count_d  [3];
    logic [31:0] reload_q [3];
    logic [31:0] reload_d [3];
    logic [11:0] ctrl_q;
    logic [11:0] ctrl_d;
    logic [2:0]  out_q;
    logic [2:0]  out_d;

    mode_e       mode_s      [3];
    logic [2:0]  en_s;
    logic [31:0] run_count_s [3];
    logic [2:0]  run_out_s;
    logic [2:0]  mode_chg_s;
    logic        ctrl_wr_s;

    // Decode per-channel mode/enable fields and detect mode changes on a control write
    always_comb begin
        ctrl_wr_s = counter_we && (counter_ch == 2'b11);
        for (int i = 0; i < 3; i++) begin
            mode_s[i]     = mode_e'(ctrl_q[4*i +: 2]);
            en_s[i]       = ctrl_q[4*i + 2];
            mode_chg_s[i] = (counter_val[4*i +: 2] != ctrl_q[4*i +: 2]);
        end
    end

    // Free-running channel behaviour (idle / decrement / expire) ignoring bus writes
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            run_count_s[i] = count_q[i];
            run_out_s[i]   = out_q[i];
            if (en_s[i] && (count_q[i] == 32'd1)) begin
                case (mode_s[i])
                    MODE_PERIODIC: begin
                        run_count_s[i] = reload_q[i];
                        run_out_s[i]   = 1'b1;
                    end
                    MODE_SQUARE: begin
                        run_count_s[i] = reload_q[i];
                        run_out_s[i]   = ~out_q[i];
                    end
                    default: begin
                        // one-shot (and the 11 encoding): park at zero, out sticks high
                        run_count_s[i] = 32'd0;
                        run_out_s[i]   = 1'b1;
                    end
                endcase
            end else if (en_s[i] && (count_q[i] > 32'd1)) begin
                run_count_s[i] = count_q[i] - 32'd1;
                // a periodic pulse lasts only for the cycle after expiry
                if (mode_s[i] == MODE_PERIODIC) begin
                    run_out_s[i] = 1'b0;
                end else begin
                    run_out_s[i] = out_q[i];
                end
            end else begin
                run_count_s[i] = count_q[i];
                run_out_s[i]   = out_q[i];
            end
        end
    end

    // Next state: a bus write to a channel overrides its own count activity
    always_comb begin
        if (ctrl_wr_s) begin
            ctrl_d = counter_val[11:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        for (int i = 0; i < 3; i++) begin
            if (counter_we && (counter_ch == 2'(i))) begin
                count_d[i]  = counter_val;
                reload_d[i] = counter_val;
                out_d[i]    = 1'b0;
            end else if (ctrl_wr_s && mode_chg_s[i]) begin
                count_d[i]  = run_count_s[i];
                reload_d[i] = reload_q[i];
                out_d[i]    = 1'b0;
            end else begin
                count_d[i]  = run_count_s[i];
                reload_d[i] = reload_q[i];
                out_d[i]    = run_out_s[i];
            end
        end
    end

    // State registers with synchronous reset; a write in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                count_q[i]  <= 32'd0;
                reload_q[i] <= 32'd0;
            end
            ctrl_q <= 12'd0;
            out_q  <= 3'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
            end
            ctrl_q <= ctrl_d;
            out_q  <= out_d;
        end
    end

    // Readback mux, independent of the write strobe
    always_comb begin
        case (counter_ch)
            2'b00:   counter_out = count_q[0];
            2'b01:   counter_out = count_q[1];
            2'b10:   counter_out = count_q[2];
            default: counter_out = {20'h0, ctrl_q};
        endcase
    end

    assign counter0_out = out_q[0];
    assign counter1_out = out_q[1];
    assign counter2_out = out_q[2];

endmodule

// File: tb/tb_counter_x.sv
// -----------------------------------------------------------------------------
// tb_counter_x
//   Self-checking bench for counter_x: directed scenarios with hand-computed
//   expectations, then randomized bus traffic compared every cycle against a
//   behavioural model of the three channels.
// -----------------------------------------------------------------------------
module tb_counter_x;

    logic        clk = 1'b0;
    logic        rst;
    logic        counter_we;
    logic [1:0]  counter_ch;
    logic [31:0] counter_val;
    logic [31:0] counter_out;
    logic        counter0_out;
    logic        counter1_out;
    logic        counter2_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // behavioural model state
    logic [31:0] m_cnt [3];
    logic [31:0] m_rel [3];
    logic [11:0] m_ctrl;
    logic [2:0]  m_out;

    counter_x dut (
        .clk          (clk),
        .rst          (rst),
        .counter_we   (counter_we),
        .counter_ch   (counter_ch),
        .counter_val  (counter_val),
        .counter_out  (counter_out),
        .counter0_out (counter0_out),
        .counter1_out (counter1_out),
        .counter2_out (counter2_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] ch);
        if (ch == 2'd3) return {20'h0, m_ctrl};
        return m_cnt[ch];
    endfunction

    // One clock edge of the reference behaviour
    task automatic model_edge(input logic r, input logic we, input logic [1:0] ch,
                              input logic [31:0] v);
        logic [11:0] old_ctrl;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 32'd0;
                m_rel[i] = 32'd0;
            end
            m_out  = 3'd0;
            m_ctrl = 12'd0;
        end else begin
            old_ctrl = m_ctrl;
            for (int i = 0; i < 3; i++) begin
                logic       en;
                logic [1:0] md;
                en = old_ctrl[4*i + 2];
                md = old_ctrl[4*i +: 2];
                if (en && m_cnt[i] == 32'd1) begin
                    if (md == 2'd1) begin
                        m_cnt[i] = m_rel[i];
                        m_out[i] = 1'b1;
                    end else if (md == 2'd2) begin
                        m_cnt[i] = m_rel[i];
                        m_out[i] = !m_out[i];
                    end else begin
                        m_cnt[i] = 32'd0;
                        m_out[i] = 1'b1;
                    end
                end else if (en && m_cnt[i] > 32'd1) begin
                    m_cnt[i] = m_cnt[i] - 32'd1;
                    if (md == 2'd1) m_out[i] = 1'b0;
                end
            end
            if (we) begin
                if (ch != 2'd3) begin
                    m_cnt[ch] = v;
                    m_rel[ch] = v;
                    m_out[ch] = 1'b0;
                end else begin
                    for (int i = 0; i < 3; i++)
                        if (v[4*i +: 2] != old_ctrl[4*i +: 2]) m_out[i] = 1'b0;
                    m_ctrl = v[11:0];
                end
            end
        end
    endtask

    always @(posedge clk) model_edge(rst, counter_we, counter_ch, counter_val);

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_out0", {31'd0, counter0_out}, {31'd0, m_out[0]});
            check("cmp_out1", {31'd0, counter1_out}, {31'd0, m_out[1]});
            check("cmp_out2", {31'd0, counter2_out}, {31'd0, m_out[2]});
            check("cmp_rdbk", counter_out, m_read(counter_ch));
        end
    end

    task automatic drive(input logic r, input logic we, input logic [1:0] ch,
                         input logic [31:0] v);
        rst         = r;
        counter_we  = we;
        counter_ch  = ch;
        counter_val = v;
        @(posedge clk);
        #2;
        rst        = 1'b0;
        counter_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          r;
        logic [1:0]  c;

        rst = 1'b1; counter_we = 1'b0; counter_ch = 2'd0; counter_val = 32'd0;
        drive(1'b1, 1'b0, 2'd0, 32'd0);
        chk_en = 1'b1;

        // reset state: every selector reads 0, outputs low
        for (int k = 0; k < 4; k++) begin
            counter_ch = 2'(k);
            #1;
            check("rst_rdbk", counter_out, 32'd0);
        end
        check("rst_outs", {29'd0, counter2_out, counter1_out, counter0_out}, 32'd0);

        // one-shot ch0 = 5
        drive(1'b0, 1'b1, 2'd3, 32'h004);
        drive(1'b0, 1'b1, 2'd0, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            check("oneshot_out", {31'd0, counter0_out}, (k == 5) ? 32'd1 : 32'd0);
        end
        idle(3);
        check("oneshot_hold", {31'd0, counter0_out}, 32'd1);
        counter_ch = 2'd0; #1;
        check("oneshot_cnt0", counter_out, 32'd0);

        // periodic ch1 = 3
        drive(1'b1, 1'b0, 2'd0, 32'd0);
        drive(1'b0, 1'b1, 2'd3, 32'h050);
        drive(1'b0, 1'b1, 2'd1, 32'd3);
        check("per_cnt_init", counter_out, 32'd3);
        for (int k = 1; k <= 9; k++) begin
            idle(1);
            check("per_out", {31'd0, counter1_out}, (k % 3 == 0) ? 32'd1 : 32'd0);
            check("per_cnt", counter_out, (k % 3 == 0) ? 32'd3 : 32'(3 - (k % 3)));
        end

        // square ch2 = 4, freeze and resume
        drive(1'b1, 1'b0, 2'd0, 32'd0);
        drive(1'b0, 1'b1, 2'd3, 32'h600);
        drive(1'b0, 1'b1, 2'd2, 32'd4);
        for (int k = 1; k <= 10; k++) begin
            idle(1);
            check("sq_out", {31'd0, counter2_out}, 32'((k / 4) % 2));
        end
        drive(1'b0, 1'b1, 2'd3, 32'h200);
        counter_ch = 2'd2;
        idle(5);
        check("sq_frz_cnt", counter_out, 32'd1);
        check("sq_frz_out", {31'd0, counter2_out}, 32'd0);
        drive(1'b0, 1'b1, 2'd3, 32'h600);
        counter_ch = 2'd2; #1;
        check("sq_resume_cnt", counter_out, 32'd1);
        idle(1);
        check("sq_resume_out", {31'd0, counter2_out}, 32'd1);
        check("sq_resume_rl", counter_out, 32'd4);

        // write colliding with periodic expiry
        drive(1'b1, 1'b0, 2'd0, 32'd0);
        drive(1'b0, 1'b1, 2'd3, 32'h005);
        drive(1'b0, 1'b1, 2'd0, 32'd2);
        idle(1);
        drive(1'b0, 1'b1, 2'd0, 32'd7);
        check("coll_out", {31'd0, counter0_out}, 32'd0);
        check("coll_cnt", counter_out, 32'd7);
        for (int k = 1; k <= 7; k++) begin
            idle(1);
            check("coll_next", {31'd0, counter0_out}, (k == 7) ? 32'd1 : 32'd0);
        end

        // zero loads produce nothing
        drive(1'b1, 1'b0, 2'd0, 32'd0);
        drive(1'b0, 1'b1, 2'd3, 32'h054);
        drive(1'b0, 1'b1, 2'd0, 32'd0);
        drive(1'b0, 1'b1, 2'd1, 32'd0);
        idle(10);
        check("zero_outs", {30'd0, counter1_out, counter0_out}, 32'd0);
        counter_ch = 2'd3; #1;
        check("zero_ctrl", counter_out, 32'h054);

        // maximum load value
        drive(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF);
        check("max_load", counter_out, 32'hFFFF_FFFF);
        idle(1);
        check("max_dec", counter_out, 32'hFFFF_FFFE);

        // reset mid-count with a coinciding write
        drive(1'b1, 1'b0, 2'd0, 32'd0);
        drive(1'b0, 1'b1, 2'd3, 32'h004);
        drive(1'b0, 1'b1, 2'd0, 32'd10);
        idle(3);
        drive(1'b1, 1'b1, 2'd0, 32'd2);
        for (int k = 0; k < 4; k++) begin
            counter_ch = 2'(k);
            #1;
            check("rstmid_rdbk", counter_out, 32'd0);
        end
        idle(15);
        check("rstmid_out", {29'd0, counter2_out, counter1_out, counter0_out}, 32'd0);

        // randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
            end else if (r < 20) begin
                c = 2'($urandom_range(0, 3));
                if (c == 2'd3) begin
                    v = $urandom;
                end else begin
                    r = $urandom_range(0, 15);
                    if (r == 0)      v = 32'd0;
                    else if (r == 1) v = 32'hFFFF_FFFF;
                    else             v = 32'($urandom_range(1, 12));
                end
                drive(1'b0, 1'b1, c, v);
            end else begin
                counter_ch  = 2'($urandom_range(0, 3));
                counter_val = $urandom;
                idle(1);
            end
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
